// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl
//   Scanned driver for a 5-column x 7-row LED matrix. A 2-of-5 code word is
//   taken over a valid/ready handshake into a one-entry pending buffer. At a
//   frame boundary (or on start from IDLE) it is decoded to a digit glyph and
//   the five columns are lit one at a time from an internal 5x7 font.
//
//   Optional build macro SCAN_DIM_EN adds the 'dim' input: while dim=1 the
//   row pattern is only driven during the first half of each column dwell.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          scan enable; low forces IDLE with outputs off
//   dim         (SCAN_DIM_EN only) half-dwell row drive
//   code[4:0]   2-of-5 word, weights 7,4,2,1,0 for bits 4..0
//   code_valid  code presented
//   code_ready  pending buffer empty
//   col[4:0]    one-hot column select, col[0] = leftmost
//   row[6:0]    row pattern, bit0 = top row
//   err         displayed word was not a valid 2-of-5 code
//   frame_tick  high during the last cycle of each 5-column frame
module matrix_scan_ctrl #(
    parameter int DWELL_CYCLES = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
`ifdef SCAN_DIM_EN
    input  logic       dim,
`endif
    input  logic [4:0] code,
    input  logic       code_valid,
    output logic       code_ready,
    output logic [4:0] col,
    output logic [6:0] row,
    output logic       err,
    output logic       frame_tick
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
`ifdef SCAN_DIM_EN
    // first dwell count at which rows go dark when dimmed: ceil(DWELL/2)
    localparam logic [CW-1:0] DIM_OFF = CW'((DWELL_CYCLES + 1) / 2);
`endif

    localparam logic [3:0] GLYPH_E = 4'd10;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_full_q, pend_full_d;
    logic [4:0]    pend_code_q, pend_code_d;
    logic          act_vld_q, act_vld_d;
    logic [3:0]    glyph_q, glyph_d;
    logic          err_q, err_d;
    logic [4:0]    col_q, col_d;
    logic [6:0]    row_q, row_d;
    logic          tick_q, tick_d;

    logic          load, adv;
    logic [2:0]    pop;
    logic [3:0]    wsum;
    logic          dec_err;
    logic [3:0]    dec_glyph;

    // Column bytes of each glyph, leftmost column first.
    function automatic logic [6:0] font(input logic [3:0] g, input logic [2:0] c);
        logic [0:4][6:0] f;
        case (g)
            4'd0:    f = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
            4'd1:    f = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
            4'd2:    f = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
            4'd3:    f = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
            4'd4:    f = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
            4'd5:    f = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
            4'd6:    f = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
            4'd7:    f = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
            4'd8:    f = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
            4'd9:    f = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
            default: f = {7'h7F, 7'h49, 7'h49, 7'h49, 7'h41};
        endcase
        return (c <= 3'd4) ? f[c] : 7'h00;
    endfunction

    // Decode of the pending word; only consumed at a load.
    always_comb begin
        pop  = 3'(pend_code_q[4]) + 3'(pend_code_q[3]) + 3'(pend_code_q[2])
             + 3'(pend_code_q[1]) + 3'(pend_code_q[0]);
        wsum = (pend_code_q[4] ? 4'd7 : 4'd0) + (pend_code_q[3] ? 4'd4 : 4'd0)
             + (pend_code_q[2] ? 4'd2 : 4'd0) + (pend_code_q[1] ? 4'd1 : 4'd0);
        dec_err   = (pop != 3'd2);
        dec_glyph = dec_err ? GLYPH_E : ((wsum == 4'd11) ? 4'd0 : wsum);
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        pend_full_d = pend_full_q;
        pend_code_d = pend_code_q;
        act_vld_d   = act_vld_q;
        glyph_d     = glyph_q;
        err_d       = err_q;
        load        = 1'b0;
        adv         = 1'b0;

        // Accept never collides with load: load needs a full buffer.
        if (code_valid && !pend_full_q) begin
            pend_full_d = 1'b1;
            pend_code_d = code;
        end

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_full_q || act_vld_q) begin
                        load    = pend_full_q;
                        idx_d   = 3'd0;
                        cnt_d   = '0;
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (cnt_q == DWELL_LAST) begin
                        cnt_d = '0;
                        if (BLANK_CYCLES > 0) state_d = BLANK;
                        else                  adv     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d = '0;
                        adv   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (adv) begin
                state_d = SHOW;
                if (idx_q == 3'd4) begin
                    // frame boundary: the only place a new glyph may enter
                    idx_d = 3'd0;
                    load  = pend_full_q;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
        end

        if (load) begin
            pend_full_d = 1'b0;
            act_vld_d   = 1'b1;
            glyph_d     = dec_glyph;
            err_d       = dec_err;
        end

        // Outputs are registered, so derive them from the next state.
        col_d = 5'b0;
        row_d = 7'b0;
        if (state_d == SHOW) begin
            col_d = 5'b00001 << idx_d;
            row_d = font(glyph_d, idx_d);
`ifdef SCAN_DIM_EN
            if (dim && (cnt_d >= DIM_OFF)) row_d = 7'b0;
`endif
        end

        // Tick marks the last cycle of column 4, i.e. the boundary cycle.
        if (BLANK_CYCLES > 0)
            tick_d = (state_d == BLANK) && (idx_d == 3'd4) && (cnt_d == BLANK_LAST);
        else
            tick_d = (state_d == SHOW) && (idx_d == 3'd4) && (cnt_d == DWELL_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            pend_full_q <= 1'b0;
            pend_code_q <= 5'b0;
            act_vld_q   <= 1'b0;
            glyph_q     <= 4'd0;
            err_q       <= 1'b0;
            col_q       <= 5'b0;
            row_q       <= 7'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            pend_full_q <= pend_full_d;
            pend_code_q <= pend_code_d;
            act_vld_q   <= act_vld_d;
            glyph_q     <= glyph_d;
            err_q       <= err_d;
            col_q       <= col_d;
            row_q       <= row_d;
            tick_q      <= tick_d;
        end
    end

    assign code_ready = ~pend_full_q;
    assign col        = col_q;
    assign row        = row_q;
    assign err        = err_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
module tb_matrix_scan_ctrl;

    typedef struct packed {
        logic [4:0] col;
        logic [6:0] row;
        logic       tick;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, code_valid, code_ready, err, frame_tick;
    logic [4:0] code, col;
    logic [6:0] row;
    logic       en1, valid1, ready1, err1, tick1;
    logic [4:0] code1, col1;
    logic [6:0] row1;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    logic acc_next = 1'b0;

    logic [6:0] FONT [0:10][0:4] = '{
        '{7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E},
        '{7'h00, 7'h42, 7'h7F, 7'h40, 7'h00},
        '{7'h42, 7'h61, 7'h51, 7'h49, 7'h46},
        '{7'h21, 7'h41, 7'h45, 7'h4B, 7'h31},
        '{7'h18, 7'h14, 7'h12, 7'h7F, 7'h10},
        '{7'h27, 7'h45, 7'h45, 7'h45, 7'h39},
        '{7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30},
        '{7'h01, 7'h71, 7'h09, 7'h05, 7'h03},
        '{7'h36, 7'h49, 7'h49, 7'h49, 7'h36},
        '{7'h06, 7'h49, 7'h49, 7'h29, 7'h1E},
        '{7'h7F, 7'h49, 7'h49, 7'h49, 7'h41}
    };

    always #5 clk = ~clk;

    matrix_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(1)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .code(code), .code_valid(code_valid),
        .code_ready(code_ready), .col(col), .row(row), .err(err), .frame_tick(frame_tick)
    );

    matrix_scan_ctrl #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .code(code1), .code_valid(valid1),
        .code_ready(ready1), .col(col1), .row(row1), .err(err1), .frame_tick(tick1)
    );

    // Bench-side code model: weights 7,4,2,1,0 on bits 4..0.
    function automatic logic code_bad(input logic [4:0] c);
        int n = 0;
        for (int i = 0; i < 5; i++) n += int'(c[i]);
        return (n != 2);
    endfunction

    function automatic int glyph_of(input logic [4:0] c);
        int w[5] = '{0, 1, 2, 4, 7};
        int s = 0;
        if (code_bad(c)) return 10;
        for (int i = 0; i < 5; i++) if (c[i]) s += w[i];
        return (s == 11) ? 0 : s;
    endfunction

    function automatic exp_t mk(input logic [4:0] c, input logic [6:0] r,
                                input logic t, input logic e);
        exp_t x;
        x.col = c; x.row = r; x.tick = t; x.err = e;
        return x;
    endfunction

    task automatic cmp_vec(input string tag, input exp_t obs, input exp_t req);
        n_vec++;
        assert (obs === req)
        else begin
            n_bad++;
            $error("FAIL %s: observed col=%b row=%h tick=%b err=%b, expected col=%b row=%h tick=%b err=%b",
                   tag, obs.col, obs.row, obs.tick, obs.err, req.col, req.row, req.tick, req.err);
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
        n_vec++;
        assert (obs === req)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic push_off(input int n, input logic e);
        for (int i = 0; i < n; i++) exp_q.push_back(mk(5'b0, 7'h00, 1'b0, e));
    endtask

    // Push the first n cycles of a DWELL=4/BLANK=1 frame of glyph g.
    task automatic push_frame(input int g, input logic e, input int n);
        int k = 0;
        for (int c = 0; c < 5; c++) begin
            for (int d = 0; d < 4; d++) begin
                if (k < n) exp_q.push_back(mk(5'(1) << c, FONT[g][c], 1'b0, e));
                k++;
            end
            if (k < n) exp_q.push_back(mk(5'b0, 7'h00, (c == 4), e));
            k++;
        end
    endtask

    // One cycle: compare the next expected entry, then run the handshake.
    task automatic step(input string tag);
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp_vec(tag, mk(col, row, frame_tick, err), e);
        end
        if (acc_next) begin
            code_valid = 1'b0;
            acc_next   = 1'b0;
        end else if (code_valid && code_ready) begin
            acc_next = 1'b1;
        end
    endtask

    task automatic run_q(input string tag);
        int guard = 0;
        while (exp_q.size() > 0 && guard < 2000) begin
            step(tag);
            guard++;
        end
    endtask

    task automatic offer(input logic [4:0] c);
        code       = c;
        code_valid = 1'b1;
        acc_next   = code_ready;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; code = 5'b0; code_valid = 1'b0;
        en1 = 1'b0; code1 = 5'b0; valid1 = 1'b0;

        // reset state
        push_off(3, 1'b0);
        run_q("reset");
        chk("reset ready", 8'(code_ready), 8'd1);
        rst_n = 1'b1;
        en    = 1'b1;
        push_off(4, 1'b0);
        run_q("idle no code");
        chk("idle ready", 8'(code_ready), 8'd1);

        // digit 0 (11000 = 7+4 = 11 -> 0), one off cycle before the load
        offer(5'b11000);
        push_off(1, 1'b0);
        push_frame(glyph_of(5'b11000), code_bad(5'b11000), 25);
        step("load latency");
        chk("ready after accept", 8'(code_ready), 8'd0);
        run_q("frame digit0");

        // mid-frame accept: rest of frame stays digit 0
        push_frame(0, 1'b0, 25);
        for (int i = 0; i < 3; i++) step("frame B");
        offer(5'b01100);
        push_frame(glyph_of(5'b01100), code_bad(5'b01100), 25);
        push_frame(glyph_of(5'b00110), code_bad(5'b00110), 25);
        step("frame B");
        chk("ready mid-frame", 8'(code_ready), 8'd0);
        offer(5'b00110);
        for (int i = 4; i < 25; i++) begin
            step("frame B");
            chk("ready held until boundary", 8'(code_ready), 8'd0);
        end
        step("frame C");
        chk("ready after boundary load", 8'(code_ready), 8'd1);
        run_q("frames C/D");

        // invalid word -> glyph E with err, then a valid word clears it
        offer(5'b11100);
        push_frame(3, 1'b0, 25);
        push_frame(glyph_of(5'b11100), code_bad(5'b11100), 25);
        run_q("frames E/F err");
        offer(5'b00110);
        push_frame(10, 1'b1, 25);
        push_frame(glyph_of(5'b00110), code_bad(5'b00110), 25);
        run_q("frames G/H clear err");

        // en drop during column 2, then restart at column 0
        push_frame(3, 1'b0, 12);
        run_q("pre en drop");
        en = 1'b0;
        push_off(3, 1'b0);
        run_q("en low");
        chk("ready en low", 8'(code_ready), 8'd1);
        en = 1'b1;
        push_frame(3, 1'b0, 25);
        run_q("re-enable");

        // reset mid-scan with a word pending
        push_frame(3, 1'b0, 7);
        offer(5'b10010);
        run_q("pre reset");
        rst_n = 1'b0;
        code_valid = 1'b0;
        acc_next = 1'b0;
        #1;
        cmp_vec("async reset", mk(col, row, frame_tick, err), mk(5'b0, 7'h00, 1'b0, 1'b0));
        chk("async reset ready", 8'(code_ready), 8'd1);
        push_off(2, 1'b0);
        run_q("in reset");
        rst_n = 1'b1;
        push_off(4, 1'b0);
        run_q("pending lost");

        // DWELL=1, BLANK=0: one column per clock, tick every 5 clocks
        en1 = 1'b1; code1 = 5'b10001; valid1 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0;
        chk("u1 ready after accept", 8'(ready1), 8'd0);
        cmp_vec("u1 load latency", mk(col1, row1, tick1, err1), mk(5'b0, 7'h00, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cmp_vec("u1 fast scan", mk(col1, row1, tick1, err1),
                    mk(5'(1) << (i % 5), FONT[glyph_of(5'b10001)][i % 5], (i % 5 == 4), 1'b0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
